// File: rtl/vect_dispatch.sv
// Vector dispatcher: queues {instr, rs1}, broadcasts one instruction at a time to all lanes, retires when every lane reports.
// Latency: push at t -> lane_req_o at t+2; last lane pulse at u -> done_o at u+1, next lane_req_o at u+3.
// Backpressure: instr_ready_o drops while the FIFO is full; optional VDISP_WATCHDOG_EN bounds the wait for lanes.

package vect_pkg;

   localparam logic [6:0] VARITH = 7'h57;

   typedef struct packed {
      logic [5:0] funct6;
      logic       vm;
      logic [4:0] vs2;
      logic [4:0] vs1;
      logic [2:0] funct3;
      logic [4:0] vd;
      logic [6:0] opcode;
   } arithm_instr_t;

endpackage

module vect_dispatch
   import vect_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 256
) (
   input  logic                            clk_i,
   input  logic                            resetn_i,
   input  logic                            instr_valid_i,
   input  arithm_instr_t                   instr_i,
   input  logic [DATA_WIDTH-1:0]           rs1_i,
   output logic                            instr_ready_o,
   output logic                            lane_req_o,
   output logic                            lane_instr_valid_o,
   output arithm_instr_t                   lane_instr_o,
   output logic [DATA_WIDTH-1:0]           lane_rs1_o,
   input  logic [LANES-1:0]                lane_ready_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic [$clog2(FIFO_DEPTH):0]     level_o,
   output logic                            error_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      arithm_instr_t           instr;
      logic [DATA_WIDTH-1:0]   rs1;
   } entry_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

   entry_t           mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level;
   logic             push;
   logic             pop;
   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic [LANES-1:0] done_mask;
   logic             all_done;
   logic             wd_expire;

   // Ready depends only on the registered level, never on a same-cycle pop.
   assign instr_ready_o      = (level != LW'(FIFO_DEPTH));
   assign push               = instr_valid_i && instr_ready_o;
   assign pop                = (state == RETIRE);
   assign all_done           = &(done_mask | lane_ready_i);
   assign lane_instr_valid_o = (state != IDLE);
   assign busy_o             = (state != IDLE) || (level != '0);
   assign level_o            = level;

   // FIFO payload storage; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= {instr_i, rs1_i};
      end
   end

   // FIFO pointers and occupancy; push+pop together leaves level unchanged.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and decoded strobes.
   always_comb begin
      state_nxt  = state;
      load       = 1'b0;
      lane_req_o = 1'b0;
      done_o     = 1'b0;
      case (state)
         IDLE: begin
            if (level != '0) begin
               load      = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            lane_req_o = 1'b1;
            state_nxt  = WAIT;
         end
         WAIT: begin
            // A lane's final pulse counts in the cycle it arrives.
            if (all_done || wd_expire) begin
               state_nxt = RETIRE;
            end
         end
         RETIRE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Held broadcast operands: change only when the head is loaded in IDLE.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         lane_instr_o <= '0;
         lane_rs1_o   <= '0;
      end else if (load) begin
         lane_instr_o <= mem[rd_ptr].instr;
         lane_rs1_o   <= mem[rd_ptr].rs1;
      end
   end

   // Completion mask: cleared at issue, accumulates pulses only while waiting.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         done_mask <= '0;
      end else if (state == ISSUE) begin
         done_mask <= '0;
      end else if (state == WAIT) begin
         done_mask <= done_mask | lane_ready_i;
      end
   end

`ifdef VDISP_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] wd_cnt;
   logic          error_q;

   assign wd_expire = (state == WAIT) && !all_done && (wd_cnt == CW'(TIMEOUT - 1));
   assign error_o   = error_q;

   // Watchdog: counts WAIT cycles; expiry forces a normal retire and sets a sticky flag.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wd_cnt  <= '0;
         error_q <= 1'b0;
      end else begin
         if (state == ISSUE) begin
            wd_cnt <= '0;
         end else if (state == WAIT) begin
            wd_cnt <= wd_cnt + CW'(1);
         end
         if (wd_expire) begin
            error_q <= 1'b1;
         end
      end
   end
`else
   // Without the watchdog WAIT holds until every lane reports.
   logic unused_timeout;

   assign wd_expire      = 1'b0;
   assign error_o        = 1'b0;
   assign unused_timeout = (TIMEOUT != 0);
`endif

endmodule

// File: doc/vect_dispatch.md
# vect_dispatch

Single-instruction-in-flight dispatcher between the scalar core's vector issue port and the LANES `lane` instances. It buffers `arithm_instr_t` instructions and their scalar `rs1` operands in a small FIFO. It broadcasts one instruction at a time to all lanes with a one-cycle request pulse, holds instruction and `rs1` stable for the whole execution, and collects each lane's one-cycle `ready_o` completion pulse. It retires the instruction only when every lane has reported.

## Interface
- DATA_WIDTH, 32, scalar operand width; equals lane DATA_WIDTH.
- LANES, 4, number of lanes served; width of `lane_ready_i`.
- FIFO_DEPTH, 4, instruction queue entries; power of two, ≥2.
- TIMEOUT, 256, watchdog limit in cycles spent in WAIT (used only with VDISP_WATCHDOG_EN).

Ports:
- clk_i  in  1  clock.
- resetn_i  in  1  reset, asynchronous, active-low.
- instr_valid_i  in  1  upstream instruction valid.
- instr_i  in  arithm_instr_t  instruction from vect_pkg.
- rs1_i  in  DATA_WIDTH  scalar operand accompanying instr_i.
- instr_ready_o  out  1  FIFO not full; push on valid&&ready.
- lane_req_o  out  1  one-cycle broadcast request, to lane `instr_req_i`.
- lane_instr_valid_o  out  1  high from ISSUE through RETIRE, to lane `instr_valid_i`.
- lane_instr_o  out  arithm_instr_t  held instruction, to lane `instr_i`.
- lane_rs1_o  out  DATA_WIDTH  held operand, to lane `rs1_rdata_i`.
- lane_ready_i  in  LANES  per-lane completion pulses (lane `ready_o`).
- busy_o  out  1  FSM not IDLE or FIFO non-empty.
- done_o  out  1  one-cycle retire pulse.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- error_o  out  1  sticky watchdog flag.

## Operation
- FIFO: registered storage of {instr, rs1}, wrapping read/write pointers, level counter 0..FIFO_DEPTH.
  - Push when instr_valid_i && instr_ready_o.
  - Pop only in RETIRE.
  - Push and pop in the same cycle leave level unchanged. This is legal at full only if instr_ready_o was already high, so a full FIFO never accepts.
  - instr_ready_o = (level != FIFO_DEPTH), registered-path only, with no dependency on pop.
- FSM states: IDLE, ISSUE, WAIT, RETIRE.
  - IDLE: if level != 0, load head into lane_instr_o/lane_rs1_o registers; go to ISSUE.
  - ISSUE: lane_req_o=1; clear the done mask; go to WAIT.
  - WAIT: done_mask |= lane_ready_i each cycle. Go to RETIRE when (done_mask | lane_ready_i) is all-ones, so a final pulse counts in its own cycle.
  - RETIRE: pop FIFO; done_o=1; go to IDLE.
- lane_instr_o and lane_rs1_o change only on the IDLE→ISSUE transition. They are stable from ISSUE until the next load.
- lane_ready_i pulses outside WAIT are ignored.
- A duplicate pulse from one lane is idempotent.

## Timing
- Reset values: all outputs 0 except instr_ready_o=1; FSM IDLE; pointers, level, and mask 0; lane_instr_o='0.
- Reset mid-operation aborts the in-flight instruction and empties the FIFO. No done_o is emitted.
- Latency:
  - Push at cycle t gives level=1 at t+1 and lane_req_o at t+2.
  - Last lane pulse at cycle u gives RETIRE and done_o at u+1.
  - The next lane_req_o is at u+3 if the FIFO is non-empty.
- Minimum occupancy per instruction is 4 cycles (ISSUE, WAIT with all pulses in the first cycle, RETIRE, IDLE).
- level_o and instr_ready_o update the cycle after push or pop.

## Configuration
- VDISP_WATCHDOG_EN defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT-1 without all lanes reporting, error_o is set (sticky until reset) and the FSM is forced to RETIRE. The instruction is popped and done_o pulses normally.
- VDISP_WATCHDOG_EN undefined:
  - No counter is built and error_o is tied 0.
  - WAIT waits indefinitely.

## Test plan
- Single push, instr opcode=VARITH, rs1=0xDEADBEEF: lane_req_o one pulse at t+2, lane_rs1_o=0xDEADBEEF. All lanes pulse at u: done_o at u+1, level_o back to 0.
- Staggered lane pulses (lane0 at c, lane3 at c+5, lanes1/2 at c+2): done_o exactly at c+6. lane_instr_o is unchanged throughout.
- Push 5 back-to-back with FIFO_DEPTH=4 while lanes are stalled: instr_ready_o=0 after the 4th accept, 5th held. Retire frees one slot, and the 5th is accepted the next cycle.
- Push at the same cycle as RETIRE with level=3: level stays 3. Order is preserved, and the 4 issued instr vs2 fields arrive in push order.
- resetn_i low during WAIT with level=2: all outputs go to reset values immediately and no done_o follows. A fresh push issues normally.
- VDISP_WATCHDOG_EN, TIMEOUT=16, lane2 never pulses: error_o=1 and done_o after 16 WAIT cycles. The next instruction still issues, and error_o stays 1.
